// File: rtl/wr_sram_bind_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wr_sram_bind_arbiter
// Purpose  : Round-robin binder that gives port write paths exclusive use of
//            SRAM banks. At most one new binding is made per cycle. A binding
//            is held until its port releases it. o_sram_busy goes back to the
//            SRAM matchers as their "accessible" qualifier.
// Ports    : clk, rst        clock; asynchronous active-high reset
//            i_bind_req      per-port request level
//            i_bind_sram     per-port requested bank, slice [p*W +: W]
//            i_release       per-port pulse that frees the bound bank
//            o_bind_grant    registered one-hot (or zero) grant pulse
//            o_port_bound    port currently holds a bank
//            o_port_sram     bank held by each port (0 when unbound)
//            o_sram_busy     bank currently bound to some port
//            o_conflict_cnt  saturating count of lost-arbitration cycles
// Config   : `define ARB_STATS_EN to build the conflict counter; otherwise
//            o_conflict_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module wr_sram_bind_arbiter #(
    parameter int PORT_NUM   = 16,
    parameter int SRAM_NUM   = 32,
    parameter int SRAM_IDX_W = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUM-1:0]            i_bind_req,
    input  logic [PORT_NUM*SRAM_IDX_W-1:0] i_bind_sram,
    input  logic [PORT_NUM-1:0]            i_release,
    output logic [PORT_NUM-1:0]            o_bind_grant,
    output logic [PORT_NUM-1:0]            o_port_bound,
    output logic [PORT_NUM*SRAM_IDX_W-1:0] o_port_sram,
    output logic [SRAM_NUM-1:0]            o_sram_busy,
    output logic [15:0]                    o_conflict_cnt
);

    localparam int c_PTR_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    // Bank masks are built over the full index space so that any index value
    // selects a real bit; only the low SRAM_NUM bits are ever stored.
    localparam int c_IDX_SPAN = 1 << SRAM_IDX_W;

    logic [PORT_NUM-1:0]   r_grant;
    logic [PORT_NUM-1:0]   r_bound;
    logic [SRAM_IDX_W-1:0] r_sram [PORT_NUM];
    logic [SRAM_NUM-1:0]   r_busy;
    logic [c_PTR_W-1:0]    r_rr_ptr;

    logic [SRAM_IDX_W-1:0] w_req_idx [PORT_NUM];
    logic [c_IDX_SPAN-1:0] w_busy_ext;
    logic [PORT_NUM-1:0]   w_pend;
    logic [PORT_NUM-1:0]   w_elig;
    logic [PORT_NUM-1:0]   w_rel;
    logic [2*PORT_NUM-1:0] w_dbl;
    logic                  w_win_vld;
    logic [c_PTR_W-1:0]    w_win_idx;
    logic [c_PTR_W:0]      w_sum;
    logic [c_PTR_W-1:0]    w_next_ptr;
    logic [PORT_NUM-1:0]   w_win_oh;
    logic [c_IDX_SPAN-1:0] w_set_ext;
    logic [c_IDX_SPAN-1:0] w_clr_ext;

    always_comb begin
        w_busy_ext                 = '0;
        w_busy_ext[SRAM_NUM-1:0]   = r_busy;
    end

    // Pending = wants a bank it could legally hold; eligible additionally
    // needs that bank free. Everything is taken from registered state.
    generate
        for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
            logic w_in_range;
            assign w_req_idx[p] = i_bind_sram[p*SRAM_IDX_W +: SRAM_IDX_W];
            assign w_in_range   = ({1'b0, w_req_idx[p]} < (SRAM_IDX_W+1)'(SRAM_NUM));
            assign w_pend[p]    = i_bind_req[p] & ~r_bound[p] & w_in_range;
            assign w_elig[p]    = w_pend[p] & ~w_busy_ext[w_req_idx[p]];
            assign o_port_sram[p*SRAM_IDX_W +: SRAM_IDX_W] = r_sram[p];
        end
    endgenerate

    assign w_rel = i_release & r_bound;

    // Rotate the eligible vector so bit 0 is the port at r_rr_ptr; the first
    // set bit is then the scan winner at offset i from the pointer.
    assign w_dbl = {w_elig, w_elig} >> r_rr_ptr;

    always_comb begin
        w_win_vld = 1'b0;
        w_sum     = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (!w_win_vld && w_dbl[i]) begin
                w_win_vld = 1'b1;
                w_sum     = {1'b0, r_rr_ptr} + (c_PTR_W+1)'(i);
            end
        end
        if (w_sum >= (c_PTR_W+1)'(PORT_NUM)) begin
            w_sum = w_sum - (c_PTR_W+1)'(PORT_NUM);
        end
        w_win_idx = w_sum[c_PTR_W-1:0];
    end

    assign w_next_ptr = (w_win_idx == c_PTR_W'(PORT_NUM-1)) ? '0 : w_win_idx + 1'b1;
    assign w_win_oh   = w_win_vld ? (PORT_NUM'(1) << w_win_idx) : '0;

    // A winner's bank is free and a releasing port's bank is busy, so the
    // set and clear masks never touch the same bank in one cycle.
    always_comb begin
        w_set_ext = '0;
        w_clr_ext = '0;
        if (w_win_vld) begin
            w_set_ext[w_req_idx[w_win_idx]] = 1'b1;
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_rel[p]) begin
                w_clr_ext[r_sram[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_bound  <= '0;
            r_busy   <= '0;
            r_rr_ptr <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                r_sram[p] <= '0;
            end
        end else begin
            r_grant <= w_win_oh;
            r_bound <= (r_bound & ~w_rel) | w_win_oh;
            r_busy  <= (r_busy & ~w_clr_ext[SRAM_NUM-1:0]) | w_set_ext[SRAM_NUM-1:0];
            for (int p = 0; p < PORT_NUM; p++) begin
                if (w_rel[p]) begin
                    r_sram[p] <= '0;
                end else if (w_win_oh[p]) begin
                    r_sram[p] <= w_req_idx[p];
                end
            end
            if (w_win_vld) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic        w_conflict;
    logic [15:0] r_conflict_cnt;

    // Some in-range, unbound requester did not win this cycle.
    assign w_conflict = |(w_pend & ~w_win_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`else
    assign o_conflict_cnt = 16'h0;
`endif

    assign o_bind_grant = r_grant;
    assign o_port_bound = r_bound;
    assign o_sram_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wr_sram_bind_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_sram_bind_arbiter
// Purpose  : Self-checking bench for wr_sram_bind_arbiter (16 ports, 32 banks,
//            6-bit index so out-of-range requests are representable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_sram_bind_arbiter;

    localparam int P = 16;
    localparam int S = 32;
    localparam int W = 6;
`ifdef ARB_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   bind_req;
    logic [P*W-1:0] bind_sram;
    logic [P-1:0]   rel;
    logic [P-1:0]   grant;
    logic [P-1:0]   bound;
    logic [P*W-1:0] psram;
    logic [S-1:0]   busy;
    logic [15:0]    ccnt;

    always #5 clk = ~clk;

    wr_sram_bind_arbiter #(
        .PORT_NUM   (P),
        .SRAM_NUM   (S),
        .SRAM_IDX_W (W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_bind_req     (bind_req),
        .i_bind_sram    (bind_sram),
        .i_release      (rel),
        .o_bind_grant   (grant),
        .o_port_bound   (bound),
        .o_port_sram    (psram),
        .o_sram_busy    (busy),
        .o_conflict_cnt (ccnt)
    );

    typedef struct {
        logic [15:0] req;
        logic [15:0] rel;
        logic [15:0] grant;
        logic [15:0] bound;
        logic [31:0] busy;
        int          inc;
        int          cport;
        int          csram;
    } vec_t;

    vec_t vecs[17];
    vec_t sbq[$];
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   exp_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_sram(input int p, input int v);
        bind_sram[p*W +: W] = W'(v);
    endtask

    function automatic vec_t mk(input logic [15:0] rq, input logic [15:0] rl,
                                input logic [15:0] g, input logic [15:0] b,
                                input logic [31:0] bz, input int inc,
                                input int cp, input int cs);
        vec_t v;
        v.req = rq; v.rel = rl; v.grant = g; v.bound = b; v.busy = bz;
        v.inc = inc; v.cport = cp; v.csram = cs;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        rst       = 1'b1;
        bind_req  = '0;
        rel       = '0;
        bind_sram = '0;
        #1;
        check("reset_grant", 64'(grant), 64'h0);
        check("reset_bound", 64'(bound), 64'h0);
        check("reset_busy",  64'(busy),  64'h0);
        check("reset_ccnt",  64'(ccnt),  64'h0);

        set_sram(0, 40); set_sram(1, 12); set_sram(2, 2);  set_sram(3, 7);
        set_sram(4, 12); set_sram(5, 5);  set_sram(6, 20); set_sram(7, 9);
        set_sram(9, 12); set_sram(15, 31);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        //            req       rel       grant     bound     busy          inc port sram
        vecs[0]  = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h00000000, 0, -1, 0);
        vecs[1]  = mk(16'h0008, 16'h0000, 16'h0008, 16'h0008, 32'h00000080, 0,  3, 7);
        vecs[2]  = mk(16'h0000, 16'h0000, 16'h0000, 16'h0008, 32'h00000080, 0,  3, 7);
        vecs[3]  = mk(16'h0010, 16'h0000, 16'h0010, 16'h0018, 32'h00001080, 0,  4, 12);
        vecs[4]  = mk(16'h0000, 16'h0010, 16'h0000, 16'h0008, 32'h00000080, 0,  4, 0);
        vecs[5]  = mk(16'h0212, 16'h0000, 16'h0200, 16'h0208, 32'h00001080, 1,  9, 12);
        vecs[6]  = mk(16'h0012, 16'h0000, 16'h0000, 16'h0208, 32'h00001080, 1, -1, 0);
        vecs[7]  = mk(16'h0012, 16'h0200, 16'h0000, 16'h0008, 32'h00000080, 1,  9, 0);
        vecs[8]  = mk(16'h0012, 16'h0000, 16'h0002, 16'h000A, 32'h00001080, 1,  1, 12);
        vecs[9]  = mk(16'h0010, 16'h0000, 16'h0000, 16'h000A, 32'h00001080, 1, -1, 0);
        vecs[10] = mk(16'h0041, 16'h0000, 16'h0040, 16'h004A, 32'h00101080, 0,  6, 20);
        vecs[11] = mk(16'h0041, 16'h0040, 16'h0000, 16'h000A, 32'h00001080, 0,  6, 0);
        vecs[12] = mk(16'h0041, 16'h0000, 16'h0040, 16'h004A, 32'h00101080, 0,  6, 20);
        vecs[13] = mk(16'h0001, 16'h0000, 16'h0000, 16'h004A, 32'h00101080, 0,  0, 0);
        vecs[14] = mk(16'h8000, 16'h0000, 16'h8000, 16'h804A, 32'h80101080, 0, 15, 31);
        vecs[15] = mk(16'h0024, 16'h0000, 16'h0004, 16'h804E, 32'h80101084, 1,  2, 2);
        vecs[16] = mk(16'h0020, 16'h0000, 16'h0020, 16'h806E, 32'h801010A4, 0,  5, 5);

        for (int i = 0; i < 17; i++) begin
            bind_req = vecs[i].req;
            rel      = vecs[i].rel;
            sbq.push_back(vecs[i]);
            step();
            e = sbq.pop_front();
            exp_cnt += e.inc;
            check($sformatf("v%0d_grant", i), 64'(grant), 64'(e.grant));
            check($sformatf("v%0d_bound", i), 64'(bound), 64'(e.bound));
            check($sformatf("v%0d_busy", i),  64'(busy),  64'(e.busy));
            check($sformatf("v%0d_ccnt", i),  64'(ccnt),  c_STATS ? 64'(exp_cnt) : 64'h0);
            if (e.cport >= 0) begin
                check($sformatf("v%0d_psram%0d", i, e.cport),
                      64'(psram[e.cport*W +: W]), 64'(e.csram));
            end
        end
        bind_req = '0;
        rel      = '0;

        // Asynchronous reset while ports 2 and 5 are bound, checked before
        // the next clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_grant", 64'(grant), 64'h0);
        check("async_bound", 64'(bound), 64'h0);
        check("async_busy",  64'(busy),  64'h0);
        check("async_psram", 64'(psram), 64'h0);
        check("async_ccnt",  64'(ccnt),  64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pointer restarts at 0: port 3 beats port 7.
        bind_req = 16'h0088;
        step();
        check("post_rst_grant", 64'(grant), 64'h0008);
        bind_req = '0;
        step();

        // Ports 1 and 4 fight for bank 12; the loser waits forever.
        bind_req = 16'h0012;
        step();
        check("sat_first_grant", 64'(grant), 64'h0010);
        check("sat_first_ccnt", 64'(ccnt), c_STATS ? 64'h1 : 64'h0);
        repeat (c_STATS ? 70000 : 200) @(posedge clk);
        #1;
        check("sat_ccnt", 64'(ccnt), c_STATS ? 64'hFFFF : 64'h0);
        step();
        check("sat_hold_ccnt", 64'(ccnt), c_STATS ? 64'hFFFF : 64'h0);
        check("sat_port1_unbound", 64'(bound[1]), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
